div3_serializer: RTL and testbench

DIV3_SERIALIZER -- requirements
Module: div3_serializer

---
 rtl/div3_serializer_if.sv | 19 +
 rtl/div3_serializer.sv | 55 +++++
 tb/tb_div3_serializer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/div3_serializer_if.sv
// div3_serializer_if: parallel-in / serial-out handshake bundle for div3_serializer
interface div3_serializer_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ser_bit;
    logic             ser_valid;
    logic             ser_ready;
    logic             ser_last;
    logic             ser_first;
    modport master (
        output in_data, in_valid, ser_ready,
        input  in_ready, ser_bit, ser_valid, ser_last, ser_first
    );
    modport slave (
        input  in_data, in_valid, ser_ready,
        output in_ready, ser_bit, ser_valid, ser_last, ser_first
    );
endinterface

// File: rtl/div3_serializer.sv
// div3_serializer: MSB-first word serializer feeding a divide-by-3 detector, with sent-word counter
module div3_serializer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    div3_serializer_if.slave       bus,
    output logic [CNT_W-1:0]       word_cnt
);
    localparam int IW = $clog2(WIDTH);
    localparam logic [1:0] IDLE  = 2'b01;
    localparam logic [1:0] SHIFT = 2'b10;

    logic [1:0]       state;
    logic [WIDTH-1:0] sreg;
    logic [IW-1:0]    idx;
    logic             in_shift, in_hs, ser_hs;

    assign in_shift      = state == SHIFT;
    assign bus.ser_valid = in_shift;
    assign bus.ser_bit   = in_shift & sreg[WIDTH-1];
    assign bus.ser_first = in_shift && idx == IW'(WIDTH-1);
    assign bus.ser_last  = in_shift && idx == '0;
    assign bus.in_ready  = state == IDLE || (bus.ser_last && bus.ser_ready);
    assign in_hs         = bus.in_valid && bus.in_ready;
    assign ser_hs        = bus.ser_valid && bus.ser_ready;

    // load on input handshake (also back-to-back on the last bit), shift on serial handshake
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            sreg  <= '0;
            idx   <= '0;
        end else if (in_hs) begin
            state <= SHIFT;
            sreg  <= bus.in_data;
            idx   <= IW'(WIDTH-1);
        end else if (ser_hs) begin
            state <= bus.ser_last ? IDLE : SHIFT;
            sreg  <= sreg << 1;
            idx   <= bus.ser_last ? idx : idx - IW'(1);
        end else if (state != IDLE && state != SHIFT) begin
            state <= IDLE;
        end
    end

    // count only words whose final bit has been accepted downstream
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            word_cnt <= '0;
        else if (ser_hs && bus.ser_last)
            word_cnt <= word_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_div3_serializer.sv
// tb_div3_serializer: directed checks of serialization order, stalls, back-to-back, reset and counter wrap
module tb_div3_serializer;
    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic [3:0] word_cnt;
    logic [3:0] exp_cnt = '0;
    int         ncmp = 0;
    int         nerr = 0;
    int         rem = 0;

    div3_serializer_if #(.WIDTH(8)) bus ();

    div3_serializer #(.WIDTH(8), .CNT_W(4)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (bus.slave),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(bus.ser_valid), 0);
        check({tag, "_bit"},   32'(bus.ser_bit),   0);
        check({tag, "_first"}, 32'(bus.ser_first), 0);
        check({tag, "_last"},  32'(bus.ser_last),  0);
        check({tag, "_rdy"},   32'(bus.in_ready),  1);
        check({tag, "_cnt"},   32'(word_cnt),      0);
    endtask

    task automatic reset_pulse();
        rstn = 1'b0;
        #1;
        check_reset_outputs("rst");
        exp_cnt = '0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // entered just after a rising edge with the DUT idle; stalls stall_len cycles on bit stall_at
    task automatic serialize(input logic [7:0] d, input int stall_at, input int stall_len, input int abort_after);
        int b = 0;
        int st = 0;
        int cyc = 0;
        rem = 0;
        bus.in_data   = d;
        bus.in_valid  = 1'b1;
        bus.ser_ready = 1'b1;
        @(negedge clk);
        check("ld_rdy", 32'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = ~d;
        while (b < 8 && cyc < 40) begin
            if (b == abort_after) return;
            bus.ser_ready = !(b == stall_at && st < stall_len);
            @(negedge clk);
            check("valid", 32'(bus.ser_valid), 1);
            check("bit",   32'(bus.ser_bit),   32'(d[7-b]));
            check("first", 32'(bus.ser_first), 32'(b == 0));
            check("last",  32'(bus.ser_last),  32'(b == 7));
            check("in_rdy", 32'(bus.in_ready), 32'(b == 7 && bus.ser_ready));
            if (bus.ser_ready) begin
                rem = (rem * 2 + int'(bus.ser_bit)) % 3;
                b++;
            end else
                st++;
            cyc++;
            @(posedge clk);
            #1;
        end
        bus.ser_ready = 1'b1;
        check("cycles", 32'(cyc), 32'(8 + stall_len));
        exp_cnt = exp_cnt + 4'd1;
        check("cnt", 32'(word_cnt), 32'(exp_cnt));
        check("idle", 32'(bus.ser_valid), 0);
    endtask

    initial begin
        logic [15:0] w2 = 16'hFF03;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.ser_ready = 1'b0;
        #2;
        reset_pulse();

        serialize(8'h96, -1, 0, 99);
        check("div3_96", 32'(rem), 0);

        bus.ser_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hFF;
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = i < 8;
            bus.in_data  = (i == 7) ? 8'h03 : 8'($urandom);
            @(negedge clk);
            check("b2b_valid", 32'(bus.ser_valid), 1);
            check("b2b_bit",   32'(bus.ser_bit),   32'(w2[15-i]));
            check("b2b_rdy",   32'(bus.in_ready),  32'(i == 7 || i == 15));
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        exp_cnt = exp_cnt + 4'd2;
        check("b2b_idle", 32'(bus.ser_valid), 0);
        check("b2b_cnt",  32'(word_cnt), 3);

        serialize(8'hA5, 4, 3, 99);

        serialize(8'h5A, -1, 0, 5);
        reset_pulse();
        serialize(8'h01, -1, 0, 99);
        check("post_rst_cnt", 32'(word_cnt), 1);

        reset_pulse();
        for (int k = 1; k <= 17; k++) begin
            serialize(8'(k * 7), -1, 0, 99);
            if (k == 15) check("wrap15", 32'(word_cnt), 15);
            if (k == 16) check("wrap16", 32'(word_cnt), 0);
            if (k == 17) check("wrap17", 32'(word_cnt), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
